instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
RV32I decode stage sitting directly downstream of instruction_fetch; consumes its pc/insn/valid stream. Produces a registered, fully decoded instruction bundle for the execute stage. Also detects load-use hazards against the instruction it currently holds, inserts a bubble and requests a front-end stall. Honours pipeline stall (hold) and flush (squash on redirect).

Parameters:
NOP_INSN, 32'h0000_0013, encoding reported on insn_out when the bundle is invalid (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  pc_in/insn_in carry a real instruction this cycle (fetch run_out)
pc_in  in  32  pc of insn_in
insn_in  in  32  raw instruction word
stall  in  1  downstream hold: keep all output registers unchanged
flush  in  1  redirect taken: squash the incoming and the held instruction
hazard_stall  out  1  combinational request to fetch to hold pc/insn (load-use)
valid_out  out  1  bundle valid
pc_out  out  32  registered pc
insn_out  out  32  registered raw word (NOP_INSN when invalid)
rd, rs1, rs2  out  5 each  register indices (forced 0 when unused by the format)
imm  out  32  sign-extended immediate
funct3  out  3  registered funct3
alu_op  out  4  mspu_decode_pkg::alu_op_t
alu_src_imm  out  1  operand B = imm
alu_src_pc  out  1  operand A = pc (AUIPC, JAL)
reg_we, mem_re, mem_we, is_branch, is_jal, is_jalr, is_system, illegal  out  1 each  control flags

Behaviour:
- Latency: 1 cycle; inputs decoded combinationally, captured at posedge into the bundle register.
- Reset: valid_out=0, all fields/flags 0, insn_out=NOP_INSN, pc_out=0. Reset mid-operation discards the held bundle.
- Priority per cycle: reset > flush > stall > hazard > normal capture.
- flush: next cycle valid_out=0, flags cleared, insn_out=NOP_INSN; hazard_stall forced 0 while flush=1.
- stall (flush=0): every output register holds; hazard_stall still evaluated.
- hazard: hazard_stall=1 when valid_in & valid_out & mem_re & rd!=0 & (rd==rs1_dec | rd==rs2_dec), where rs*_dec are the incoming insn's used sources. When stall=0, capture a bubble (valid_out=0, flags 0); fetch re-presents the same insn next cycle, which then decodes normally.
- Normal: valid_out<=valid_in; if valid_in=0, capture bubble.
- Opcode classes (insn[6:0]): LUI 0110111 (alu COPY_B, imm U), AUIPC 0010111 (ADD, src_pc, imm U), JAL 1101111 (imm J, reg_we), JALR 1100111 (imm I, rs1), BRANCH 1100011 (imm B, rs1, rs2, rd=0, alu SUB), LOAD 0000011 (ADD, imm I, mem_re), STORE 0100011 (ADD, imm S, rd=0, mem_we), OP-IMM 0010011, OP 0110011, MISC-MEM 0001111 (treated as NOP, valid, no flags), SYSTEM 1110011 (is_system).
- OP: funct7[5] selects SUB/SRA; OP-IMM: funct7[5] selects SRA only for funct3=101; SUB never from OP-IMM.
- illegal=1 for insn[1:0]!=11, unlisted opcode, or OP with funct7 not in {0000000,0100000}; illegal bundle has valid_out=1, all other flags 0.
- reg_we=0 whenever rd==0.
- Immediates: I {20{i[31]},i[31:20]}; S {20{i[31]},i[31:25],i[11:7]}; B {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {11{i[31]},i[31],i[19:12],i[20],i[30:21],0}.

Decomposition:
- Package mspu_decode_pkg: opcode localparams, alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, COPY_B), imm_fmt_t enum (I,S,B,U,J,NONE), NOP constant.
- Sub-module imm_gen (combinational: insn + imm_fmt_t -> 32-bit imm). Hazard logic and bundle register stay in instruction_decode.

Test Plan:
- Reset, then valid_in=1 insn 0x00500093 pc 0x8000_0000 -> next cycle valid_out=1, rd=1, rs1=0, imm=5, alu ADD, alu_src_imm=1, reg_we=1.
- insn 0x407302B3 -> rd=5, rs1=6, rs2=7, alu SUB, alu_src_imm=0; same fields with opcode 0010011 -> alu ADD (not SUB).
- insn 0xFE000EE3 at pc 0x8000_0010 -> is_branch=1, imm=0xFFFF_FFFC, rd=0, reg_we=0.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) -> hazard_stall=1 in cycle 2, valid_out=0 in cycle 3, add captured in cycle 4 with hazard_stall=0.
- Valid bundle held, stall=1 for 3 cycles with changing insn_in -> outputs unchanged; then flush=1 with stall=1 -> valid_out=0, insn_out=0x0000_0013.
- insn 0x0000_0000 and 0xFFFF_FFFF -> illegal=1, valid_out=1, reg_we=mem_re=mem_we=0.

Source files
------------

// File: rtl/mspu_decode_pkg.sv
// Shared RV32I decode types: opcodes, ALU operation and immediate-format enums,
// and the registered bundle handed to execute.  Rev 1.0
`default_nettype none

package mspu_decode_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_COPY_B = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_fmt_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [2:0]  funct3;
      alu_op_t     alu_op;
      logic        alu_src_imm;
      logic        alu_src_pc;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        is_system;
      logic        illegal;
   } bundle_t;

   // alt selects SUB (funct3=000) or SRA (funct3=101); caller decides when alt is legal
   function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction for the I/S/B/U/J formats.  Rev 1.0
`default_nettype none

module imm_gen
   import mspu_decode_pkg::*;
(
   input  logic [31:7] insn_i,
   input  imm_fmt_t    fmt_i,
   output logic [31:0] imm_o
);

   always_comb begin
      imm_o = 32'd0;
      case (fmt_i)
         IMM_I: imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
         IMM_S: imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
         IMM_B: imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
         IMM_U: imm_o = {insn_i[31:12], 12'd0};
         IMM_J: imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
         default: imm_o = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/instruction_decode.sv
// RV32I decode stage: registered decoded bundle with load-use bubble insertion,
// downstream stall hold and redirect flush.  Rev 1.0
`default_nettype none

module instruction_decode
   import mspu_decode_pkg::*;
#(
   parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] insn_in,
   input  logic        stall,
   input  logic        flush,
   output logic        hazard_stall,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] insn_out,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] imm,
   output logic [2:0]  funct3,
   output alu_op_t     alu_op,
   output logic        alu_src_imm,
   output logic        alu_src_pc,
   output logic        reg_we,
   output logic        mem_re,
   output logic        mem_we,
   output logic        is_branch,
   output logic        is_jal,
   output logic        is_jalr,
   output logic        is_system,
   output logic        illegal
);

   bundle_t     dec_ctl;
   bundle_t     dec;
   bundle_t     bubble;
   bundle_t     bundle_d;
   bundle_t     bundle_q;
   imm_fmt_t    fmt;
   logic [31:0] imm_w;
   logic        use_rd;
   logic        use_rs1;
   logic        use_rs2;
   logic        writes_rd;
   logic        legal;
   logic        fence;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;

   assign opc = insn_in[6:0];
   assign f3  = insn_in[14:12];
   assign f7  = insn_in[31:25];

   always_comb begin
      bubble      = '0;
      bubble.insn = NOP_INSN;
   end

   always_comb begin
      dec_ctl   = '0;
      fmt       = IMM_NONE;
      use_rd    = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
      fence     = 1'b0;
      legal     = (insn_in[1:0] == 2'b11);
      case (opc)
         OPC_LUI: begin
            use_rd = 1'b1; writes_rd = 1'b1; fmt = IMM_U;
            dec_ctl.alu_op = ALU_COPY_B; dec_ctl.alu_src_imm = 1'b1;
         end
         OPC_AUIPC: begin
            use_rd = 1'b1; writes_rd = 1'b1; fmt = IMM_U;
            dec_ctl.alu_src_imm = 1'b1; dec_ctl.alu_src_pc = 1'b1;
         end
         OPC_JAL: begin
            use_rd = 1'b1; writes_rd = 1'b1; fmt = IMM_J;
            dec_ctl.alu_src_imm = 1'b1; dec_ctl.alu_src_pc = 1'b1; dec_ctl.is_jal = 1'b1;
         end
         OPC_JALR: begin
            use_rd = 1'b1; use_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I;
            dec_ctl.alu_src_imm = 1'b1; dec_ctl.is_jalr = 1'b1;
         end
         OPC_BRANCH: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B;
            dec_ctl.alu_op = ALU_SUB; dec_ctl.is_branch = 1'b1;
         end
         OPC_LOAD: begin
            use_rd = 1'b1; use_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I;
            dec_ctl.alu_src_imm = 1'b1; dec_ctl.mem_re = 1'b1;
         end
         OPC_STORE: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S;
            dec_ctl.alu_src_imm = 1'b1; dec_ctl.mem_we = 1'b1;
         end
         OPC_OP_IMM: begin
            use_rd = 1'b1; use_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I;
            dec_ctl.alu_src_imm = 1'b1;
            // bit 30 is immediate data except on shift-right, so SUB can never appear here
            dec_ctl.alu_op = alu_from_funct3(f3, (f3 == 3'b101) && insn_in[30]);
         end
         OPC_OP: begin
            use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
            dec_ctl.alu_op = alu_from_funct3(f3, insn_in[30]);
            if ((f7 != 7'b0000000) && (f7 != 7'b0100000)) begin
               legal = 1'b0;
            end
         end
         OPC_MISC_MEM: fence = 1'b1;
         OPC_SYSTEM:   dec_ctl.is_system = 1'b1;
         default:      legal = 1'b0;
      endcase

      dec_ctl.valid = 1'b1;
      dec_ctl.pc    = pc_in;
      dec_ctl.insn  = insn_in;
      if (legal) begin
         dec_ctl.rd     = use_rd  ? insn_in[11:7]  : 5'd0;
         dec_ctl.rs1    = use_rs1 ? insn_in[19:15] : 5'd0;
         dec_ctl.rs2    = use_rs2 ? insn_in[24:20] : 5'd0;
         dec_ctl.funct3 = fence ? 3'd0 : f3;
         dec_ctl.reg_we = writes_rd && (insn_in[11:7] != 5'd0);
      end else begin
         dec_ctl         = '0;
         dec_ctl.valid   = 1'b1;
         dec_ctl.pc      = pc_in;
         dec_ctl.insn    = insn_in;
         dec_ctl.illegal = 1'b1;
         fmt             = IMM_NONE;
      end
   end

   imm_gen u_imm_gen (
      .insn_i (insn_in[31:7]),
      .fmt_i  (fmt),
      .imm_o  (imm_w)
   );

   always_comb begin
      dec     = dec_ctl;
      dec.imm = imm_w;
   end

   // Load-use: the held load's destination is needed by the incoming instruction
   assign hazard_stall = !flush && valid_in && bundle_q.valid && bundle_q.mem_re
                         && (bundle_q.rd != 5'd0)
                         && ((bundle_q.rd == dec_ctl.rs1) || (bundle_q.rd == dec_ctl.rs2));

   always_comb begin
      bundle_d = bundle_q;
      if (flush) begin
         bundle_d = bubble;
      end else if (!stall) begin
         bundle_d = (hazard_stall || !valid_in) ? bubble : dec;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bundle_q <= bubble;
      end else begin
         bundle_q <= bundle_d;
      end
   end

   assign valid_out   = bundle_q.valid;
   assign pc_out      = bundle_q.pc;
   assign insn_out    = bundle_q.insn;
   assign rd          = bundle_q.rd;
   assign rs1         = bundle_q.rs1;
   assign rs2         = bundle_q.rs2;
   assign imm         = bundle_q.imm;
   assign funct3      = bundle_q.funct3;
   assign alu_op      = bundle_q.alu_op;
   assign alu_src_imm = bundle_q.alu_src_imm;
   assign alu_src_pc  = bundle_q.alu_src_pc;
   assign reg_we      = bundle_q.reg_we;
   assign mem_re      = bundle_q.mem_re;
   assign mem_we      = bundle_q.mem_we;
   assign is_branch   = bundle_q.is_branch;
   assign is_jal      = bundle_q.is_jal;
   assign is_jalr     = bundle_q.is_jalr;
   assign is_system   = bundle_q.is_system;
   assign illegal     = bundle_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed cases followed by random
// instruction streams compared against an instruction-level reference model.
`default_nettype none

module tb_instruction_decode;

   logic        clk = 1'b0;
   logic        reset, valid_in, stall, flush;
   logic [31:0] pc_in, insn_in;
   logic        hazard_stall, valid_out;
   logic [31:0] pc_out, insn_out, imm;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [3:0]  alu_op;
   logic        alu_src_imm, alu_src_pc, reg_we, mem_re, mem_we;
   logic        is_branch, is_jal, is_jalr, is_system, illegal;

   int n_assert = 0;
   int n_fail   = 0;
   logic haz_seen;
   logic last_haz;

   always #5 clk = ~clk;

   instruction_decode dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .insn_in(insn_in),
      .stall(stall), .flush(flush), .hazard_stall(hazard_stall), .valid_out(valid_out),
      .pc_out(pc_out), .insn_out(insn_out), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .funct3(funct3), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc),
      .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .is_branch(is_branch),
      .is_jal(is_jal), .is_jalr(is_jalr), .is_system(is_system), .illegal(illegal)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic [3:0]  alu;
      logic        src_imm, src_pc, we, re, mw, br, jal, jalr, sys, ill;
   } m_t;

   m_t model;

   function automatic m_t empty_bundle();
      m_t r;
      r      = '0;
      r.insn = 32'h0000_0013;
      return r;
   endfunction

   // Reference decode from the ISA rules; ALU codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 COPY_B10
   function automatic m_t ref_decode(input logic [31:0] p, input logic [31:0] w);
      m_t          d;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        ur, u1, u2, wr, legal, fence;
      logic [31:0] im, tmp;
      int          alu;
      int          base_tab [8];
      base_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
      d = '0;
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      ur = 0; u1 = 0; u2 = 0; wr = 0; fence = 0; im = 0; alu = 0;
      legal = (w[1:0] == 2'b11);
      case (op)
         7'b0110111: begin ur = 1; wr = 1; im = w & 32'hFFFF_F000; alu = 10; d.src_imm = 1; end
         7'b0010111: begin ur = 1; wr = 1; im = w & 32'hFFFF_F000; d.src_imm = 1; d.src_pc = 1; end
         7'b1101111: begin
            ur = 1; wr = 1; d.src_imm = 1; d.src_pc = 1; d.jal = 1;
            tmp = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'd0};
            im = $signed(tmp) >>> 11;
         end
         7'b1100111: begin ur = 1; u1 = 1; wr = 1; im = $signed(w) >>> 20; d.src_imm = 1; d.jalr = 1; end
         7'b1100011: begin
            u1 = 1; u2 = 1; alu = 1; d.br = 1;
            tmp = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'd0};
            im = $signed(tmp) >>> 19;
         end
         7'b0000011: begin ur = 1; u1 = 1; wr = 1; im = $signed(w) >>> 20; d.src_imm = 1; d.re = 1; end
         7'b0100011: begin
            u1 = 1; u2 = 1; d.src_imm = 1; d.mw = 1;
            tmp = {w[31:25], w[11:7], 20'd0};
            im = $signed(tmp) >>> 20;
         end
         7'b0010011: begin
            ur = 1; u1 = 1; wr = 1; im = $signed(w) >>> 20; d.src_imm = 1;
            alu = base_tab[f3];
            if (f3 == 3'd5 && w[30]) alu = 7;
         end
         7'b0110011: begin
            ur = 1; u1 = 1; u2 = 1; wr = 1;
            alu = base_tab[f3];
            if (w[30] && f3 == 3'd0) alu = 1;
            if (w[30] && f3 == 3'd5) alu = 7;
            if (f7 != 7'd0 && f7 != 7'd32) legal = 0;
         end
         7'b0001111: fence = 1;
         7'b1110011: d.sys = 1;
         default: legal = 0;
      endcase
      if (!legal) begin
         d = '0;
         d.ill = 1;
      end else begin
         d.rd  = ur ? w[11:7]  : 5'd0;
         d.rs1 = u1 ? w[19:15] : 5'd0;
         d.rs2 = u2 ? w[24:20] : 5'd0;
         d.imm = im;
         d.f3  = fence ? 3'd0 : f3;
         d.alu = alu[3:0];
         d.we  = wr && (w[11:7] != 5'd0);
      end
      d.valid = 1; d.pc = p; d.insn = w;
      return d;
   endfunction

   function automatic logic ref_hazard(input m_t q, input logic v, input logic fl, input logic [31:0] w);
      m_t d;
      d = ref_decode(32'd0, w);
      return !fl && v && q.valid && q.re && (q.rd != 0) && (q.rd == d.rs1 || q.rd == d.rs2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bundle();
      chk("valid_out", valid_out, model.valid);
      chk("pc_out", pc_out, model.pc);
      chk("insn_out", insn_out, model.insn);
      chk("rd", rd, model.rd);
      chk("rs1", rs1, model.rs1);
      chk("rs2", rs2, model.rs2);
      chk("imm", imm, model.imm);
      chk("funct3", funct3, model.f3);
      chk("alu_op", alu_op, model.alu);
      chk("alu_src_imm", alu_src_imm, model.src_imm);
      chk("alu_src_pc", alu_src_pc, model.src_pc);
      chk("reg_we", reg_we, model.we);
      chk("mem_re", mem_re, model.re);
      chk("mem_we", mem_we, model.mw);
      chk("is_branch", is_branch, model.br);
      chk("is_jal", is_jal, model.jal);
      chk("is_jalr", is_jalr, model.jalr);
      chk("is_system", is_system, model.sys);
      chk("illegal", illegal, model.ill);
   endtask

   task automatic step(input logic rst, input logic v, input logic [31:0] p, input logic [31:0] w,
                       input logic st, input logic fl);
      logic exp_h;
      @(negedge clk);
      reset = rst; valid_in = v; pc_in = p; insn_in = w; stall = st; flush = fl;
      #1;
      exp_h    = ref_hazard(model, v, fl, w);
      haz_seen = hazard_stall;
      last_haz = exp_h;
      chk("hazard_stall", hazard_stall, exp_h);
      @(posedge clk);
      if (rst || fl)            model = empty_bundle();
      else if (st)              model = model;
      else if (exp_h || !v)     model = empty_bundle();
      else                      model = ref_decode(p, w);
      #1;
      chk_bundle();
   endtask

   logic [6:0] opcs [11];

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 13);
      if (k <= 10 || k == 13) begin
         w[6:0]   = (k == 13) ? 7'b0110011 : opcs[k];
         w[11:7]  = 5'($urandom_range(0, 3));
         w[19:15] = 5'($urandom_range(0, 3));
         w[24:20] = 5'($urandom_range(0, 3));
         if (k <= 10 && opcs[k] == 7'b0110011)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end else if (k == 12) begin
         w[1:0] = 2'($urandom_range(0, 2));
      end
      return w;
   endfunction

   initial begin
      logic [31:0] w;
      opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
               7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
      reset = 1; valid_in = 0; pc_in = 0; insn_in = 0; stall = 0; flush = 0;
      model = empty_bundle();
      last_haz = 0;

      step(1, 0, 32'd0, 32'd0, 0, 0);
      step(1, 0, 32'd0, 32'd0, 0, 0);
      chk("reset_insn", insn_out, 32'h0000_0013);
      chk("reset_valid", valid_out, 0);

      step(0, 1, 32'h8000_0000, 32'h0050_0093, 0, 0);
      chk("addi_valid", valid_out, 1);
      chk("addi_rd", rd, 1);
      chk("addi_imm", imm, 5);
      chk("addi_alu", alu_op, 0);
      chk("addi_we", reg_we, 1);

      step(0, 1, 32'h8000_0004, 32'h4073_02B3, 0, 0);
      chk("sub_alu", alu_op, 1);
      chk("sub_rs2", rs2, 7);
      chk("sub_srcimm", alu_src_imm, 0);
      step(0, 1, 32'h8000_0008, 32'h4073_0293, 0, 0);
      chk("opimm_not_sub", alu_op, 0);

      step(0, 1, 32'h8000_0010, 32'hFE00_0EE3, 0, 0);
      chk("br_flag", is_branch, 1);
      chk("br_imm", imm, 32'hFFFF_FFFC);
      chk("br_we", reg_we, 0);

      step(0, 1, 32'h8000_0014, 32'h0000_A103, 0, 0);
      step(0, 1, 32'h8000_0018, 32'h0011_01B3, 0, 0);
      chk("lu_haz_c2", haz_seen, 1);
      chk("lu_bubble", valid_out, 0);
      step(0, 1, 32'h8000_0018, 32'h0011_01B3, 0, 0);
      chk("lu_haz_c3", haz_seen, 0);
      chk("lu_add_rd", rd, 3);

      for (int i = 0; i < 3; i++) begin
         step(0, 1, $urandom, $urandom, 1, 0);
         chk("stall_hold", insn_out, 32'h0011_01B3);
      end
      step(0, 1, 32'h8000_0020, 32'h0000_A103, 1, 1);
      chk("flush_valid", valid_out, 0);
      chk("flush_insn", insn_out, 32'h0000_0013);

      step(0, 1, 32'h8000_0030, 32'h0000_0000, 0, 0);
      chk("ill0", illegal, 1);
      step(0, 1, 32'h8000_0034, 32'hFFFF_FFFF, 0, 0);
      chk("ill1", illegal, 1);
      chk("ill1_valid", valid_out, 1);

      w = rand_insn();
      for (int i = 0; i < 400; i++) begin
         if (!last_haz) w = rand_insn();
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), $urandom, w,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
